// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared divider width and FSM state encoding.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } divState_t;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU that stalls the pipeline while busy.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall_req,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    divState_t state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [WIDTH-1:0] absA, absB, remNext, quotNext;
    logic [WIDTH:0] trial;
    logic qNeg, rNeg;

    assign stall_req = ((state == IDLE && start) || state == BUSY) && !cancel;

    // One extra trial bit keeps divisors above 2^(WIDTH-1) exact.
    always_comb begin
        absA = (is_signed && a[WIDTH-1]) ? -a : a;
        absB = (is_signed && b[WIDTH-1]) ? -b : b;
        trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
        remNext = trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
        quotNext = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
            valid <= 1'b0;
            lo <= '0;
            hi <= '0;
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            qNeg <= 1'b0;
            rNeg <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start && !cancel) begin
                    if (b == '0) begin
                        lo <= '1;
                        hi <= a;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        dvd <= absA;
                        dvs <= absB;
                        rem <= '0;
                        count <= '0;
                        qNeg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rNeg <= is_signed && a[WIDTH-1];
                        state <= BUSY;
                    end
                end
                BUSY: if (cancel) begin
                    state <= IDLE;
                end else begin
                    rem <= remNext;
                    dvd <= quotNext;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        lo <= qNeg ? -quotNext : quotNext;
                        hi <= rNeg ? -remNext : remNext;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed and randomized DIV/DIVU traffic.
module tb_div_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } res_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic isSigned = 1'b0;
    logic cancel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic stallReq, valid;
    logic [W-1:0] lo, hi;

    res_t expQ[$];
    res_t got;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .is_signed(isSigned),
        .a(a),
        .b(b),
        .cancel(cancel),
        .stall_req(stallReq),
        .valid(valid),
        .lo(lo),
        .hi(hi)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, results taken modulo 2^32.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        longint q, r, sx, sy;
        res_t res;
        if (y == '0) begin
            res.lo = '1;
            res.hi = x;
            return res;
        end
        sx = s ? longint'($signed(x)) : longint'({32'b0, x});
        sy = s ? longint'($signed(y)) : longint'({32'b0, y});
        q = sx / sy;
        r = sx % sy;
        res.lo = q[W-1:0];
        res.hi = r[W-1:0];
        return res;
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1 && valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedValid: got lo=%h hi=%h expected no result", lo, hi);
            end else begin
                got = expQ.pop_front();
                check("lo", lo, got.lo);
                check("hi", hi, got.hi);
            end
        end
    end

    // Issues one op starting in the current cycle; cancelAt<0 means no cancel.
    task automatic runDiv(input logic [W-1:0] da, input logic [W-1:0] db, input bit s,
                          input int cancelAt, input bit keepStart);
        int lat;
        lat = (db == '0) ? 1 : W + 1;
        start = 1'b1;
        a = da;
        b = db;
        isSigned = s;
        cancel = 1'b0;
        if (cancelAt < 0 || cancelAt == lat) expQ.push_back(model(da, db, s));
        for (int c = 0; c <= lat; c++) begin
            if (c == cancelAt) cancel = 1'b1;
            @(negedge clk);
            if (c == cancelAt) begin
                check("stallOnCancel", stallReq, 0);
                check("validOnCancel", valid, c == lat);
                @(posedge clk);
                #1;
                cancel = 1'b0;
                break;
            end
            check("stallReq", stallReq, c < lat);
            check("validTiming", valid, c == lat);
            @(posedge clk);
            #1;
            if (c == 0) begin
                a = $urandom;
                b = $urandom;
                isSigned = 1'($urandom_range(1));
            end
        end
        if (!keepStart) start = 1'b0;
    endtask

    task automatic resetMidBusy();
        start = 1'b1;
        a = 100;
        b = 7;
        isSigned = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        resetn = 1'b0;
        start = 1'b0;
        #1;
        check("rstStall", stallReq, 0);
        check("rstValid", valid, 0);
        check("rstLo", lo, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("resetStall", stallReq, 0);
        check("resetValid", valid, 0);
        check("resetLo", lo, 0);
        check("resetHi", hi, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        runDiv(100, 7, 0, -1, 0);
        runDiv(32'hFFFF_FFF9, 2, 1, -1, 0);
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 0);
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0);
        runDiv(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, -1, 0);
        runDiv(5, 0, 0, -1, 0);
        runDiv(32'hFFFF_FFF0, 0, 1, -1, 0);
        runDiv(100, 7, 0, 10, 1);
        runDiv(9, 3, 0, -1, 0);
        runDiv(5, 0, 0, 1, 0);
        resetMidBusy();
        runDiv(9, 3, 0, -1, 0);
        runDiv(100, 7, 0, -1, 1);
        runDiv(20, 6, 0, -1, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
            runDiv(ra, rb, 1'($urandom_range(1)), -1, 1'($urandom_range(1)));
        end
        repeat (3) @(posedge clk);
        #1;
        check("queueDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
